// File: rtl/frame_gate_pkg.sv
// Shared types and widths for the frame_gate receive buffer.
package frame_gate_pkg;

    localparam int BYTE_W = 8;
    // RAM word carries the end-of-frame flag above the data byte: {last, byte}
    localparam int WORD_W = BYTE_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        VERDICT,
        DISCARD
    } state_t;

endpackage

// File: rtl/frame_gate_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module frame_gate_ram
    import frame_gate_pkg::*;
#(
    parameter int DEPTH = 2048,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write and synchronous read; read data holds while re is low
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_gate.sv
// Store-and-forward gate: packs dibits into bytes, buffers each frame and
// releases only frames whose checksum verdict passes.
module frame_gate
    import frame_gate_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    input  logic              done,
    input  logic              kill,
    output logic              axiov,
    output logic [BYTE_W-1:0] axiod,
    output logic              axiolast,
    input  logic              axiir,
    output logic [15:0]       frames_ok,
    output logic [15:0]       frames_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t state, state_nxt;

    logic [1:0]        cnt;
    logic [1:0]        cnt_eff;
    logic [5:0]        sh;
    logic [BYTE_W-1:0] pend_byte;
    logic              pend_vld;
    logic [TW-1:0]     timer;

    logic [PW-1:0] wptr, cptr, rptr, wptr_nxt;

    logic accept, byte_done, wr_try, wr_last, full, we;
    logic commit, drop;
    logic rd_en, out_ready, vld_p1;
    logic [WORD_W-1:0] rdata_p1;

    // Dibits are taken whenever a frame is live; the first dibit of a frame
    // may arrive in IDLE or VERDICT, where the byte count restarts at zero.
    assign accept    = axiiv && (state != DISCARD);
    assign cnt_eff   = (state == RECV) ? cnt : 2'd0;
    assign byte_done = accept && (cnt_eff == 2'd3);

    // The held byte is written when its successor completes or at frame end.
    assign wr_try   = (state == RECV) && pend_vld && (axiiv ? byte_done : 1'b1);
    assign wr_last  = ~axiiv;
    assign full     = (wptr - rptr) == PW'(DEPTH);
    assign we       = wr_try && !full;
    assign wptr_nxt = we ? wptr + 1'b1 : wptr;

    // Reader: only committed data is visible; refill the RAM stage when it
    // is empty or moving into the output register.
    assign out_ready = !axiov || axiir;
    assign rd_en     = (rptr != cptr) && (!vld_p1 || out_ready);

    // Next-state and frame commit/drop decisions
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (axiiv) state_nxt = RECV;
            end
            RECV: begin
                if (wr_try && full) begin
                    if (axiiv) begin
                        state_nxt = DISCARD;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (!axiiv) begin
                    if (!pend_vld) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                    end else if (done) begin
                        commit    = !kill;
                        drop      = kill;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = VERDICT;
                    end
                end
            end
            VERDICT: begin
                if (done) begin
                    commit = !kill;
                    drop   = kill;
                end else if ((timer == TW'(TIMEOUT)) || axiiv) begin
                    drop = 1'b1;
                end
                if (done || (timer == TW'(TIMEOUT)) || axiiv) begin
                    state_nxt = axiiv ? RECV : IDLE;
                end
            end
            DISCARD: begin
                if (!axiiv) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, verdict timer and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt == VERDICT) ? timer + 1'b1 : '0;
            if (commit) frames_ok <= frames_ok + 16'd1;
            if (drop) frames_drop <= frames_drop + 16'd1;
        end
    end

    // Packer control: dibit position and hold-register occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            pend_vld <= 1'b0;
        end else begin
            if (accept) cnt <= cnt_eff + 2'd1;
            pend_vld <= (state == RECV && axiiv) ? (pend_vld | byte_done) : 1'b0;
        end
    end

    // Packer data: MSB-first shift and one-byte hold register
    always_ff @(posedge clk) begin
        if (accept) sh <= {sh[3:0], axiid};
        if (byte_done) pend_byte <= {sh, axiid};
    end

    // Write, commit and read pointers; a drop rewinds the write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            cptr <= '0;
            rptr <= '0;
        end else begin
            if (drop) wptr <= cptr;
            else if (we) wptr <= wptr + 1'b1;
            if (commit) cptr <= wptr_nxt;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    frame_gate_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr[AW-1:0]),
        .wdata ({wr_last, pend_byte}),
        .re    (rd_en),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata_p1)
    );

    // RAM read stage valid
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else if (rd_en) vld_p1 <= 1'b1;
        else if (out_ready) vld_p1 <= 1'b0;
    end

    // Output register, held until accepted downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            axiov    <= 1'b0;
            axiod    <= '0;
            axiolast <= 1'b0;
        end else if (out_ready) begin
            axiov <= vld_p1;
            if (vld_p1) begin
                axiod    <= rdata_p1[BYTE_W-1:0];
                axiolast <= rdata_p1[BYTE_W];
            end
        end
    end

endmodule

// File: tb/tb_frame_gate.sv
// Directed bench for frame_gate with a queue model of released bytes.
module tb_frame_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        done;
    logic        kill;
    logic        axiov;
    logic [7:0]  axiod;
    logic        axiolast;
    logic        axiir;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    int         exp_ok   = 0;
    int         exp_drop = 0;
    logic [7:0] rx_log [256];
    int         rx_n = 0;

    logic bp_mode   = 1'b0;
    logic rdy_level = 1'b1;

    logic       held = 1'b0;
    logic [7:0] held_d;
    logic       held_l;

    frame_gate #(.DEPTH(64), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .axiiv       (axiiv),
        .axiid       (axiid),
        .done        (done),
        .kill        (kill),
        .axiov       (axiov),
        .axiod       (axiod),
        .axiolast    (axiolast),
        .axiir       (axiir),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop)
    );

    always #5 clk = ~clk;

    // Downstream ready: steady level or 1010... toggling
    always @(posedge clk) begin
        #1;
        if (bp_mode) axiir = ~axiir;
        else axiir = rdy_level;
    end

    // Output checker: every accepted byte must be the next expected one,
    // and a stalled byte must not change
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (!axiov || axiod != held_d || axiolast != held_l) begin
                    bad++;
                    $display("FAIL hold: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                             axiov, axiod, axiolast, held_d, held_l);
                end
            end
            if (axiov && axiir) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_byte: got d=%02h l=%0b, required no output", axiod, axiolast);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({axiolast, axiod} != e) begin
                        bad++;
                        $display("FAIL byte: got l=%0b d=%02h, required l=%0b d=%02h",
                                 axiolast, axiod, e[8], e[7:0]);
                    end
                    if (rx_n < 256) rx_log[rx_n] = axiod;
                    rx_n++;
                end
            end
            held   = axiov && !axiir;
            held_d = axiod;
            held_l = axiolast;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_frame(input int nbytes, input int extra, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < nbytes * 4 + extra; i++) begin
            b = base + 8'(i / 4);
            @(posedge clk);
            #1;
            axiiv = 1'b1;
            axiid = b[7 - 2 * (i % 4) -: 2];
        end
        @(posedge clk);
        #1;
        axiiv = 1'b0;
        axiid = 2'b00;
    endtask

    task automatic verdict(input int gap, input logic k);
        repeat (gap) @(posedge clk);
        #1;
        done = 1'b1;
        kill = k;
        @(posedge clk);
        #1;
        done = 1'b0;
        kill = 1'b0;
    endtask

    task automatic expect_frame(input int nbytes, input logic [7:0] base);
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back({(i == nbytes - 1), base + 8'(i)});
        end
        exp_ok++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        chk({name, "_ok"}, int'(frames_ok), exp_ok & 16'hffff);
        chk({name, "_drop"}, int'(frames_drop), exp_drop & 16'hffff);
    endtask

    task automatic chk_reset_outputs(input string name);
        @(negedge clk);
        chk({name, "_axiov"}, int'(axiov), 0);
        chk({name, "_axiod"}, int'(axiod), 0);
        chk({name, "_axiolast"}, int'(axiolast), 0);
        chk({name, "_frames_ok"}, int'(frames_ok), 0);
        chk({name, "_frames_drop"}, int'(frames_drop), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; axiiv = 1'b0; axiid = 2'b00; done = 1'b0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Good frame 0x00..0x0F, verdict two cycles after frame end
        rx_n = 0;
        send_frame(16, 0, 8'h00);
        expect_frame(16, 8'h00);
        verdict(2, 1'b0);
        drain("good");
        chk("good_first_byte", int'(rx_log[0]), 8'h00);
        chk("good_last_byte", int'(rx_log[15]), 8'h0F);
        chk("good_count", rx_n, 16);
        chk("good_frames_ok_literal", int'(frames_ok), 1);

        // Failed checksum, then a good frame
        send_frame(16, 0, 8'h00);
        exp_drop++;
        verdict(2, 1'b1);
        send_frame(16, 0, 8'h20);
        expect_frame(16, 8'h20);
        verdict(2, 1'b0);
        drain("bad_then_good");
        chk("bad_frames_drop_literal", int'(frames_drop), 1);

        // 18 dibits: four bytes, two trailing dibits discarded
        rx_n = 0;
        send_frame(4, 2, 8'hA0);
        expect_frame(4, 8'hA0);
        verdict(2, 1'b0);
        drain("odd18");
        chk("odd18_count_literal", rx_n, 4);
        chk("odd18_last_byte", int'(rx_log[3]), 8'hA3);

        // 3 dibits: no complete byte, dropped; late done ignored
        send_frame(0, 3, 8'hC0);
        exp_drop++;
        verdict(2, 1'b0);
        drain("short3");

        // Overflow with output stalled: second 40-byte frame cannot fit
        rdy_level = 1'b0;
        send_frame(40, 0, 8'h10);
        expect_frame(40, 8'h10);
        verdict(2, 1'b0);
        send_frame(40, 0, 8'h60);
        exp_drop++;
        verdict(2, 1'b0);
        repeat (10) @(posedge clk);
        rdy_level = 1'b1;
        drain("overflow");

        // Backpressure: ready toggles every cycle
        bp_mode = 1'b1;
        send_frame(12, 0, 8'hD0);
        expect_frame(12, 8'hD0);
        verdict(3, 1'b0);
        drain("backpressure");
        bp_mode = 1'b0;

        // No verdict: frame times out; a late done is ignored
        send_frame(5, 0, 8'h70);
        repeat (90) @(posedge clk);
        exp_drop++;
        verdict(1, 1'b0);
        drain("timeout");

        // Next frame starts while the previous one awaits its verdict
        send_frame(6, 0, 8'h40);
        send_frame(5, 0, 8'h80);
        exp_drop++;
        expect_frame(5, 8'h80);
        verdict(2, 1'b0);
        drain("back_to_back");

        // Reset in the middle of a frame
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            axiiv = 1'b1;
            axiid = 2'(i);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ok = 0;
        exp_drop = 0;
        chk_reset_outputs("midreset");
        send_frame(8, 0, 8'hE0);
        expect_frame(8, 8'hE0);
        verdict(2, 1'b0);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
